// File: rtl/game_input_pkg.sv
// Shared types for the game push-button conditioner: button indices,
// repeat FSM states and the fixed-priority command arbiter.
package game_input_pkg;

   localparam int NUM_BTNS = 3;

   typedef enum logic [1:0] {
      BTN_START  = 2'd0,
      BTN_MOVE   = 2'd1,
      BTN_SELECT = 2'd2
   } btn_idx_t;

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_REPEAT
   } rpt_state_t;

   // Start beats select beats move; losers are dropped, never queued.
   function automatic logic [NUM_BTNS-1:0] arbitrate(input logic startEvt,
                                                     input logic selectEvt,
                                                     input logic moveEvt);
      logic [NUM_BTNS-1:0] grant;
      grant = '0;
      if (startEvt) begin
         grant[BTN_START] = 1'b1;
      end else if (selectEvt) begin
         grant[BTN_SELECT] = 1'b1;
      end else if (moveEvt) begin
         grant[BTN_MOVE] = 1'b1;
      end
      return grant;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw push-button: 2-flop synchroniser, polarity normalise, debounce
// counter and stable level, plus a one-cycle strobe on each accepted press.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic btn_i,
   output logic lvl_o,
   output logic press_o
);

   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic             IDLE_RAW = BTN_ACTIVE_LOW;

   logic             sync1_q, sync2_q;
   logic             pressed;
   logic             lvl_q, lvl_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Synchroniser resets to the released level so reset never looks like a press.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= IDLE_RAW;
         sync2_q <= IDLE_RAW;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   assign pressed = sync2_q ^ BTN_ACTIVE_LOW;

   always_comb begin
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      if (pressed == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         lvl_d   = ~lvl_q;
         cnt_d   = '0;
         press_d = pressed;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         press_q <= press_d;
      end
   end

   assign lvl_o   = lvl_q;
   assign press_o = press_q;

endmodule

// File: rtl/game_input_conditioner.sv
// Turns the start/move/select keys into clean single-cycle commands for
// game_controller, with auto-repeat on move and one command per cycle at most.
module game_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       hrd_rst_n,
   input  logic       start_btn,
   input  logic       move_btn,
   input  logic       select_btn,
   output logic       start,
   output logic       move,
   output logic       select,
   output logic [2:0] held
);

   import game_input_pkg::*;

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RCNT_W  = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

   logic [NUM_BTNS-1:0] rawBtn;
   logic [NUM_BTNS-1:0] lvl;
   logic [NUM_BTNS-1:0] press;
   logic [NUM_BTNS-1:0] cmd_q, cmd_d;
   rpt_state_t          state_q, state_d;
   logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
   logic                repeatEvt;

   assign rawBtn = {select_btn, move_btn, start_btn};

   for (genvar b = 0; b < NUM_BTNS; b++) begin : gBtn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
      ) uDebounce (
         .clk_i  (clk),
         .rst_n_i(hrd_rst_n),
         .btn_i  (rawBtn[b]),
         .lvl_o  (lvl[b]),
         .press_o(press[b])
      );
   end

   // A released move key wins over a repeat that would fire in the same cycle.
   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      repeatEvt = 1'b0;
      if (!lvl[BTN_MOVE]) begin
         state_d = RPT_IDLE;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            RPT_IDLE: begin
               if (press[BTN_MOVE]) begin
                  state_d = RPT_DELAY;
                  rcnt_d  = '0;
               end
            end
            RPT_DELAY: begin
               if (rcnt_q == DELAY_LAST) begin
                  repeatEvt = 1'b1;
                  state_d   = RPT_REPEAT;
                  rcnt_d    = '0;
               end else begin
                  rcnt_d = rcnt_q + RCNT_W'(1);
               end
            end
            RPT_REPEAT: begin
               if (rcnt_q == PERIOD_LAST) begin
                  repeatEvt = 1'b1;
                  rcnt_d    = '0;
               end else begin
                  rcnt_d = rcnt_q + RCNT_W'(1);
               end
            end
            default: begin
               state_d = RPT_IDLE;
               rcnt_d  = '0;
            end
         endcase
      end
   end

   assign cmd_d = arbitrate(press[BTN_START], press[BTN_SELECT], press[BTN_MOVE] | repeatEvt);

   always_ff @(posedge clk or negedge hrd_rst_n) begin
      if (!hrd_rst_n) begin
         state_q <= RPT_IDLE;
         rcnt_q  <= '0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         cmd_q   <= cmd_d;
      end
   end

   assign start  = cmd_q[BTN_START];
   assign move   = cmd_q[BTN_MOVE];
   assign select = cmd_q[BTN_SELECT];
   assign held   = lvl;

endmodule
